// File: rtl/serial_add_8bit.sv
// Bit-serial adder: r = x + y + ci, one bit per clock LSB first, using a single
// full-adder slice, a registered carry and a start/busy/done handshake.
module serial_add_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             of
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             co_q, co_d;
    logic             of_q, of_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-adder slice on the current LSBs and the registered carry.
    logic             sum_bit;
    logic             carry_nxt;
    logic             cnt_last;
    logic [WIDTH-1:0] acc_shift;

    assign sum_bit   = xs_q[0] ^ ys_q[0] ^ c_q;
    assign carry_nxt = (xs_q[0] & ys_q[0]) | (xs_q[0] & c_q) | (ys_q[0] & c_q);
    assign cnt_last  = (cnt_q == CntW'(WIDTH - 1));
    assign acc_shift = {sum_bit, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        co_d    = co_q;
        of_d    = of_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    c_d     = ci;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            StRun: begin
                xs_d  = {1'b0, xs_q[WIDTH-1:1]};
                ys_d  = {1'b0, ys_q[WIDTH-1:1]};
                acc_d = acc_shift;
                c_d   = carry_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    // c_q here is the carry into the MSB.
                    r_d     = acc_shift;
                    co_d    = carry_nxt;
                    of_d    = c_q ^ carry_nxt;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            co_q    <= 1'b0;
            of_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            co_q    <= co_d;
            of_q    <= of_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = r_q;
    assign co   = co_q;
    assign of   = of_q;

endmodule

// File: tb/tb_serial_add_8bit.sv
// Directed self-checking bench for serial_add_8bit: latency, flags, ignored
// starts, result hold, asynchronous reset and back-to-back chaining.
module tb_serial_add_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] r;
    logic       co;
    logic       of;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_8bit #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .ci   (ci),
        .busy (busy),
        .done (done),
        .r    (r),
        .co   (co),
        .of   (of)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Counts edges until done is seen (sampled 1 time unit after each edge).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 20);
    endtask

    // Launch one operation from IDLE and check latency and results.
    task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                          input logic cin, input logic [7:0] er, input logic eco,
                          input logic eof);
        int lat;
        @(negedge clk);
        start = 1'b1;
        x     = xa;
        y     = ya;
        ci    = cin;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_r"}, 32'(r), 32'(er));
        check({tag, "_co"}, 32'(co), 32'(eco));
        check({tag, "_of"}, 32'(of), 32'(eof));
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int busy_cycles;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        ci    = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_r", 32'(r), 32'd0);
        check("reset_flags", {30'd0, co, of}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic add, busy high for exactly 8 cycles
        @(negedge clk);
        start = 1'b1;
        x     = 8'h05;
        y     = 8'h03;
        ci    = 1'b0;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_cycles = 0;
        lat         = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", busy_cycles, 8);
        check("t1_r", 32'(r), 32'h08);
        check("t1_flags", {30'd0, co, of}, 32'd0);
        @(posedge clk);
        #1;

        // 2, 3: flag corners
        run_op("t2a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("t2b", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t3a", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        run_op("t3b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // 4: start pulses during RUN are ignored, result then holds
        @(negedge clk);
        start = 1'b1;
        x     = 8'h10;
        y     = 8'h20;
        ci    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        do begin
            @(negedge clk);
            if (lat == 1 || lat == 4) begin
                start = 1'b1;
                x     = 8'h7F;
                y     = 8'h7F;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 20);
        start = 1'b0;
        check("t4_latency", lat, 8);
        check("t4_r", 32'(r), 32'h30);
        check("t4_flags", {30'd0, co, of}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold", {22'd0, busy, done, r}, 32'h30);
        end

        // 5: asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1;
        x     = 8'h11;
        y     = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_r", 32'(r), 32'd0);
        check("t5_rst_flags", {30'd0, co, of}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t5_no_done", {30'd0, busy, done}, 32'd0);
        end
        run_op("t5_after", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // 6: start held high, new operands presented in the DONE cycle
        @(negedge clk);
        start = 1'b1;
        x     = 8'h01;
        y     = 8'h02;
        ci    = 1'b0;
        @(posedge clk);
        #1;
        x = 8'h40;
        y = 8'h40;
        wait_done(lat);
        check("t6a_latency", lat, 8);
        check("t6a_r", 32'(r), 32'h03);
        check("t6a_flags", {30'd0, co, of}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t6_rearm", {30'd0, busy, done}, 32'h2);
        repeat (4) @(posedge clk);
        #1;
        check("t6_hold_mid_run", 32'(r), 32'h03);
        lat = 4;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t6b_latency", lat, 8);
        check("t6b_r", 32'(r), 32'h80);
        check("t6b_co", 32'(co), 32'd0);
        check("t6b_of", 32'(of), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
